// File: rtl/mc_core_seq.sv
// Multi-cycle instruction sequencer: fetches over a valid/ready bus, runs loads/stores over a
// second bus, and strobes register-file/PC writes into the existing datapath.
module mc_core_seq #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_req_valid,
  output logic [ADDR_W-1:0] ifu_req_addr,
  input  logic              ifu_req_ready,
  input  logic              ifu_rsp_valid,
  input  logic [31:0]       ifu_rsp_data,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  input  logic              dec_load,
  input  logic              dec_store,
  input  logic              dec_ebreak,
  input  logic              dec_regwr,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  input  logic [3:0]        lsu_wstrb,
  output logic              lsu_req_valid,
  output logic              lsu_req_we,
  output logic [ADDR_W-1:0] lsu_req_addr,
  output logic [31:0]       lsu_req_wdata,
  output logic [3:0]        lsu_req_wstrb,
  input  logic              lsu_req_ready,
  input  logic              lsu_rsp_valid,
  input  logic [31:0]       lsu_rsp_data,
  output logic [31:0]       load_data,
  output logic              reg_wen,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              halted,
  output logic              bus_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_REQ, S_FETCH_WAIT, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam int                TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic              waiting;

  assign ifu_req_addr = pc;
  assign waiting      = (state == S_FETCH_REQ) || (state == S_FETCH_WAIT) ||
                        (state == S_MEM_REQ)   || (state == S_MEM_WAIT);

  // The cycle that would push the wait count to TIMEOUT is the last one a handshake may land in.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    to_hit    = (to_cnt == TO_LAST);
    case (state)
      S_IDLE:       state_nxt = S_FETCH_REQ;
      S_FETCH_REQ:  if (pc[1:0] != 2'b00)  state_nxt = S_ERROR;
                    else if (ifu_req_ready) state_nxt = S_FETCH_WAIT;
                    else if (to_hit)        state_nxt = S_ERROR;
      S_FETCH_WAIT: if (ifu_rsp_valid)      state_nxt = S_EXEC;
                    else if (to_hit)        state_nxt = S_ERROR;
      S_EXEC:       if (dec_ebreak)             state_nxt = S_HALT;
                    else if (dec_load || dec_store) state_nxt = S_MEM_REQ;
                    else                        state_nxt = S_WB;
      S_MEM_REQ:    if (lsu_req_ready)      state_nxt = S_MEM_WAIT;
                    else if (to_hit)        state_nxt = S_ERROR;
      S_MEM_WAIT:   if (lsu_rsp_valid)      state_nxt = S_WB;
                    else if (to_hit)        state_nxt = S_ERROR;
      S_WB: begin
        pc_nxt    = next_pc;
        state_nxt = S_FETCH_REQ;
      end
      S_HALT:       state_nxt = S_HALT;
      S_ERROR:      state_nxt = S_ERROR;
      default:      state_nxt = S_ERROR;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      pc            <= RST_PC;
      inst          <= '0;
      load_data     <= '0;
      retire_cnt    <= '0;
      to_cnt        <= '0;
      ifu_req_valid <= 1'b0;
      lsu_req_valid <= 1'b0;
      lsu_req_we    <= 1'b0;
      reg_wen       <= 1'b0;
      retire        <= 1'b0;
      halted        <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      to_cnt        <= (waiting && state_nxt == state) ? to_cnt + TO_W'(1) : '0;
      ifu_req_valid <= (state_nxt == S_FETCH_REQ) && (pc_nxt[1:0] == 2'b00);
      lsu_req_valid <= (state_nxt == S_MEM_REQ);
      reg_wen       <= (state_nxt == S_WB) && dec_regwr && !dec_store;
      retire        <= (state_nxt == S_WB);
      halted        <= (state_nxt == S_HALT);
      bus_error     <= (state_nxt == S_ERROR);
      if (state == S_EXEC)
        lsu_req_we <= dec_store;
      if (state == S_FETCH_WAIT && ifu_rsp_valid)
        inst <= ifu_rsp_data;
      if (state == S_MEM_WAIT && lsu_rsp_valid && !lsu_req_we)
        load_data <= lsu_rsp_data;
      if (state == S_WB)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Request payload is latched once on entry to MEM_REQ and held until accepted.
  always_ff @(posedge clk) begin
    if (state == S_EXEC && state_nxt == S_MEM_REQ) begin
      lsu_req_addr  <= lsu_addr;
      lsu_req_wdata <= lsu_wdata;
      lsu_req_wstrb <= lsu_wstrb;
    end
  end

endmodule

// File: tb/tb_mc_core_seq.sv
// Bench for mc_core_seq: behavioural fetch/data memories with delay knobs and a retire scoreboard.
module tb_mc_core_seq;

  localparam int          ADDR_W    = 32;
  localparam int          TIMEOUT   = 4;
  localparam int          CNT_W     = 32;
  localparam logic [31:0] RST_PC    = 32'h8000_0000;
  localparam logic [31:0] LSU_BASE  = 32'h0000_1000;
  localparam logic [31:0] OP_ADDI   = 32'h0010_0093;
  localparam logic [31:0] OP_LW     = 32'h0000_2083;
  localparam logic [31:0] OP_SW     = 32'h0010_2023;
  localparam logic [31:0] OP_EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [ADDR_W-1:0] ifu_req_addr, pc, next_pc, lsu_addr, lsu_req_addr;
  logic [31:0] ifu_rsp_data, inst, lsu_wdata, lsu_req_wdata, lsu_rsp_data, load_data;
  logic dec_load, dec_store, dec_ebreak, dec_regwr;
  logic [3:0] lsu_wstrb, lsu_req_wstrb;
  logic lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic reg_wen, retire, halted, bus_error;
  logic [CNT_W-1:0] retire_cnt;

  mc_core_seq #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .inst(inst), .pc(pc),
    .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak), .dec_regwr(dec_regwr),
    .next_pc(next_pc), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .load_data(load_data), .reg_wen(reg_wen), .retire(retire), .retire_cnt(retire_cnt),
    .halted(halted), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic        is_load;
    logic        is_store;
    logic [31:0] ldata;
    int          lat;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] imem[logic [31:0]];
  logic [31:0] dmem[logic [31:0]];

  // knobs, written only by the main sequence
  bit          ifu_hold    = 1'b0;
  int          ifu_rdy_dly = 0;
  int          ifu_rsp_dly = 0;
  int          lsu_rdy_dly = 0;
  int          lsu_rsp_dly = 0;
  bit          npc_ovr_en  = 1'b0;
  logic [31:0] npc_ovr     = '0;
  logic [31:0] wdata_base  = '0;
  logic [3:0]  wstrb_base  = '0;

  // responder / monitor state
  logic [31:0] pert = '0;
  int          lsu_hs_cnt  = 0;
  int          fetch_cnt   = 0;
  int          ifu_vld_cyc = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  // tiny decode/next-pc model standing in for the datapath
  assign dec_load   = (inst[6:0] == 7'h03);
  assign dec_store  = (inst[6:0] == 7'h23);
  assign dec_ebreak = (inst == OP_EBREAK);
  assign dec_regwr  = (inst[6:0] == 7'h03) || (inst[6:0] == 7'h13);
  assign next_pc    = npc_ovr_en ? npc_ovr : pc + 32'd4;
  assign lsu_addr   = LSU_BASE ^ {pert[29:0], 2'b00};
  assign lsu_wdata  = wdata_base ^ pert;
  assign lsu_wstrb  = wstrb_base ^ pert[3:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd_imem(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] rd_dmem(input logic [31:0] a);
    if (dmem.exists(a)) return dmem[a];
    return 32'h0;
  endfunction

  // Bus responder: everything sampled and driven on the falling edge.
  initial begin
    bit          ifu_pend = 1'b0, lsu_pend = 1'b0, lsu_we_l = 1'b0;
    int          ifu_wait = 0, ifu_rcnt = 0, lsu_wait = 0, lsu_rcnt = 0;
    logic [31:0] ifu_addr_l = '0, lsu_addr_l = '0;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = '0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_data = '0;
    forever begin
      @(negedge clk);
      ifu_rsp_valid = 1'b0;
      if (ifu_pend) begin
        if (ifu_rcnt >= ifu_rsp_dly) begin
          ifu_rsp_valid = 1'b1; ifu_rsp_data = rd_imem(ifu_addr_l); ifu_pend = 1'b0;
        end else ifu_rcnt++;
      end
      ifu_req_ready = 1'b0;
      if (!rst) begin
        ifu_pend = 1'b0; ifu_wait = 0; lsu_wait = 0;
      end else if (ifu_req_valid && !ifu_hold) begin
        if (ifu_wait >= ifu_rdy_dly) begin
          ifu_req_ready = 1'b1; ifu_pend = 1'b1; ifu_rcnt = 0; ifu_wait = 0;
          ifu_addr_l = ifu_req_addr;
        end else ifu_wait++;
      end
      // data side: a pending response survives reset so stale responses can be replayed
      lsu_rsp_valid = 1'b0;
      if (lsu_pend) begin
        if (lsu_rcnt >= lsu_rsp_dly) begin
          lsu_rsp_valid = 1'b1; lsu_rsp_data = lsu_we_l ? 32'h0 : rd_dmem(lsu_addr_l);
          lsu_pend = 1'b0;
        end else lsu_rcnt++;
      end
      lsu_req_ready = 1'b0;
      pert = '0;
      if (rst && lsu_req_valid) begin
        if (exp_q.size() > 0) check("lsu_we", lsu_req_we, exp_q[0].is_store);
        else check("lsu_unexpected", lsu_req_valid, 1'b0);
        check("lsu_addr", lsu_req_addr, LSU_BASE);
        check("lsu_wdata", lsu_req_wdata, wdata_base);
        check("lsu_wstrb", lsu_req_wstrb, wstrb_base);
        if (lsu_wait >= lsu_rdy_dly) begin
          lsu_req_ready = 1'b1; lsu_pend = 1'b1; lsu_rcnt = 0; lsu_wait = 0;
          lsu_addr_l = lsu_req_addr; lsu_we_l = lsu_req_we;
          if (lsu_req_we) dmem[lsu_req_addr] = lsu_req_wdata;
          lsu_hs_cnt++;
        end else begin
          lsu_wait++;
          pert = 32'hFFFF_FFFF;
        end
      end
    end
  end

  // Retire monitor: pops one expected record per retire pulse.
  initial begin
    exp_t e;
    bit   prev_ifu = 1'b0;
    int   start_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        exp_q.delete();
        prev_ifu = 1'b0;
      end else begin
        if (ifu_req_valid) ifu_vld_cyc++;
        if (ifu_req_valid && !prev_ifu) begin
          fetch_cnt++;
          start_cyc = cyc;
          if (exp_q.size() > 0) check("fetch_addr", ifu_req_addr, exp_q[0].pc);
        end
        prev_ifu = ifu_req_valid;
        if (retire) begin
          if (exp_q.size() == 0) check("retire_unexpected", retire, 1'b0);
          else begin
            e = exp_q.pop_front();
            check("wb_pc", pc, e.pc);
            check("wb_reg_wen", reg_wen, e.wen);
            check("wb_latency", cyc - start_cyc + 1, e.lat);
            check("wb_retire_cnt", retire_cnt, e.cnt);
            if (e.is_load) check("wb_load_data", load_data, e.ldata);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic wen, input logic ld, input logic st,
                          input logic [31:0] ldata, input int lat, input logic [31:0] cnt);
    exp_t e;
    e.pc = a; e.wen = wen; e.is_load = ld; e.is_store = st; e.ldata = ldata; e.lat = lat; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_ifu_valid", ifu_req_valid, 1'b0);
    check("rst_lsu_valid", lsu_req_valid, 1'b0);
    check("rst_reg_wen", reg_wen, 1'b0);
    check("rst_retire", retire, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_bus_error", bus_error, 1'b0);
    check("rst_pc", pc, RST_PC);
    check("rst_inst", inst, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_retire_cnt", retire_cnt, 32'h0);
  endtask

  // Reset asserted mid-cycle so the clear has to be asynchronous to show up 1ns later.
  task automatic apply_reset();
    @(posedge clk); #3 rst = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic wait_stop(input string tag, input int budget);
    int n = 0;
    while (!(halted || bus_error) && n < budget) begin
      @(negedge clk); n++;
    end
    check(tag, halted || bus_error, 1'b1);
  endtask

  task automatic quiet_after_stop(input string tag, input logic [31:0] cnt);
    int v0 = ifu_vld_cyc;
    repeat (20) @(negedge clk);
    check({tag, "_no_fetch"}, ifu_vld_cyc - v0, 0);
    check({tag, "_cnt_held"}, retire_cnt, cnt);
  endtask

  initial begin
    int v0, f0, h0, n;
    // addi, load (ready after 3 waits), store (same delay, strobes 0011), ebreak
    imem[RST_PC] = OP_ADDI; imem[RST_PC + 4] = OP_LW;
    imem[RST_PC + 8] = OP_SW; imem[RST_PC + 12] = OP_EBREAK;
    dmem[LSU_BASE] = 32'hDEAD_BEEF;
    lsu_rdy_dly = 3; wdata_base = 32'h1234_5678; wstrb_base = 4'b0011;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    @(posedge clk); #3 rst = 1'b1;
    push_exp(RST_PC,      1'b1, 1'b0, 1'b0, 32'h0,         4, 0);
    push_exp(RST_PC + 4,  1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 9, 1);
    push_exp(RST_PC + 8,  1'b0, 1'b0, 1'b1, 32'h0,         9, 2);
    wait_stop("a_stop", 200);
    check("a_halted", halted, 1'b1);
    check("a_bus_error", bus_error, 1'b0);
    check("a_retire_cnt", retire_cnt, 3);
    check("a_pc_held", pc, RST_PC + 12);
    check("a_store_data", rd_dmem(LSU_BASE), 32'h1234_5678);
    check("a_load_kept", load_data, 32'hDEAD_BEEF);
    check("a_queue_empty", exp_q.size(), 0);
    quiet_after_stop("a_halt", 3);

    // two instructions (zero-wait store) then ebreak
    imem.delete();
    imem[RST_PC] = OP_ADDI; imem[RST_PC + 4] = OP_SW; imem[RST_PC + 8] = OP_EBREAK;
    lsu_rdy_dly = 0; wdata_base = 32'hCAFE_F00D; wstrb_base = 4'b1100;
    apply_reset();
    push_exp(RST_PC,     1'b1, 1'b0, 1'b0, 32'h0, 4, 0);
    push_exp(RST_PC + 4, 1'b0, 1'b0, 1'b1, 32'h0, 6, 1);
    wait_stop("b_stop", 200);
    check("b_halted", halted, 1'b1);
    check("b_retire_cnt", retire_cnt, 2);
    check("b_ifu_idle", ifu_req_valid, 1'b0);
    quiet_after_stop("b_halt", 2);

    // fetch never accepted: error after exactly TIMEOUT request cycles
    ifu_hold = 1'b1;
    apply_reset();
    v0 = ifu_vld_cyc;
    wait_stop("c_stop", 50);
    check("c_bus_error", bus_error, 1'b1);
    check("c_halted", halted, 1'b0);
    check("c_req_cycles", ifu_vld_cyc - v0, TIMEOUT);
    check("c_ifu_dropped", ifu_req_valid, 1'b0);
    check("c_retire_cnt", retire_cnt, 0);
    ifu_hold = 1'b0;

    // misaligned next pc: error without a second fetch request
    imem.delete();
    imem[RST_PC] = OP_ADDI;
    npc_ovr_en = 1'b1; npc_ovr = 32'h8000_0002;
    apply_reset();
    f0 = fetch_cnt;
    push_exp(RST_PC, 1'b1, 1'b0, 1'b0, 32'h0, 4, 0);
    wait_stop("d_stop", 100);
    check("d_bus_error", bus_error, 1'b1);
    check("d_fetches", fetch_cnt - f0, 1);
    check("d_pc", pc, 32'h8000_0002);
    check("d_retire_cnt", retire_cnt, 1);
    check("d_ifu_valid", ifu_req_valid, 1'b0);
    npc_ovr_en = 1'b0;

    // reset while a load waits for its response; that response arrives after release
    imem.delete();
    imem[RST_PC] = OP_LW;
    dmem[LSU_BASE] = 32'hBAD0_BAD0;
    lsu_rsp_dly = 8;
    apply_reset();
    push_exp(RST_PC, 1'b1, 1'b1, 1'b0, 32'hBAD0_BAD0, 12, 0);
    h0 = lsu_hs_cnt; n = 0;
    while (lsu_hs_cnt == h0 && n < 40) begin @(negedge clk); n++; end
    check("e_lsu_handshake", lsu_hs_cnt - h0, 1);
    @(posedge clk); #3 rst = 1'b0;
    #1 check_reset_outputs();
    imem[RST_PC] = OP_ADDI; imem[RST_PC + 4] = OP_EBREAK;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    push_exp(RST_PC, 1'b1, 1'b0, 1'b0, 32'h0, 4, 0);
    wait_stop("e_stop", 100);
    check("e_halted", halted, 1'b1);
    check("e_bus_error", bus_error, 1'b0);
    check("e_retire_cnt", retire_cnt, 1);
    check("e_stale_ignored", load_data, 32'h0);
    check("e_pc", pc, RST_PC + 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400000ns expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
